// File: rtl/riscv_alu_ahb_master.sv
// AHB-Lite master driving a memory-mapped ALU slave: writes op, A and B, then reads back the result.
// Transfers are single NONSEQ words, pipelined address/data phases, with two-cycle error handling.
package riscv_alu_ahb_pkg;
    localparam logic PROT_NOTCACHE = 1'b0;
    localparam logic PROT_UNBUF    = 1'b0;
    localparam logic PROT_USER     = 1'b0;
    localparam logic PROT_DATA     = 1'b1;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
endpackage

module riscv_alu_ahb_master
    import riscv_alu_ahb_pkg::*;
#(
    parameter int                W_ADDR    = 32,
    parameter int                W_DATA    = 32,
    parameter logic [W_ADDR-1:0] BASE_ADDR = 32'h0,
    parameter logic [3:0]        DEF_HPROT = {PROT_NOTCACHE, PROT_UNBUF, PROT_USER, PROT_DATA}
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              start_i,
    input  logic [3:0]        op_i,
    input  logic [31:0]       a_i,
    input  logic [31:0]       b_i,
    output logic              ready_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       result_o,
    output logic [1:0]        out_m_HTRANS,
    output logic [2:0]        out_m_HBURST,
    output logic [2:0]        out_m_HSIZE,
    output logic [3:0]        out_m_HPROT,
    output logic [W_ADDR-1:0] out_m_HADDR,
    output logic              out_m_HWRITE,
    output logic [W_DATA-1:0] out_m_HWDATA,
    input  logic              m_HREADY,
    input  logic [1:0]        m_HRESP,
    input  logic [W_DATA-1:0] m_HRDATA
);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_LAST, ST_ERR} state_t;

    state_t              state_r, state_s;
    logic [1:0]          idx_r, idx_s;
    logic [1:0]          htrans_r, htrans_s;
    logic [W_ADDR-1:0]   haddr_r, haddr_s;
    logic                hwrite_r, hwrite_s;
    logic [W_DATA-1:0]   hwdata_r, hwdata_s;
    logic                ready_r, ready_s;
    logic                done_r, done_s;
    logic                err_r, err_s;
    logic [31:0]         result_r, result_s;
    logic [3:0]          op_r, op_s;
    logic [31:0]         a_r, a_s, b_r, b_s;
    logic                bus_err_s;

    // Write data for transfer idx; the read slot carries no data.
    function automatic logic [W_DATA-1:0] wdata_sel(input logic [1:0] idx, input logic [3:0] op,
                                                     input logic [31:0] a, input logic [31:0] b);
        case (idx)
            2'd0:    wdata_sel = W_DATA'({28'h0, op});
            2'd1:    wdata_sel = W_DATA'(a);
            2'd2:    wdata_sel = W_DATA'(b);
            default: wdata_sel = {W_DATA{1'b0}};
        endcase
    endfunction

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        htrans_s  = htrans_r;
        haddr_s   = haddr_r;
        hwrite_s  = hwrite_r;
        hwdata_s  = hwdata_r;
        done_s    = 1'b0;
        err_s     = 1'b0;
        result_s  = result_r;
        op_s      = op_r;
        a_s       = a_r;
        b_s       = b_r;
        bus_err_s = (m_HRESP != HRESP_OKAY) && !m_HREADY;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_s  = ST_ADDR;
                    op_s     = op_i;
                    a_s      = a_i;
                    b_s      = b_i;
                    idx_s    = 2'd0;
                    htrans_s = HTRANS_NONSEQ;
                    haddr_s  = BASE_ADDR;
                    hwrite_s = 1'b1;
                end else begin
                    htrans_s = HTRANS_IDLE;
                end
            end
            ST_ADDR: begin
                // Transfer 0 has no data phase in flight yet, so HRESP is ignored then.
                if ((idx_r != 2'd0) && bus_err_s) begin
                    state_s  = ST_ERR;
                    htrans_s = HTRANS_IDLE;
                end else if (m_HREADY) begin
                    hwdata_s = wdata_sel(idx_r, op_r, a_r, b_r);
                    if (idx_r == 2'd3) begin
                        state_s  = ST_LAST;
                        htrans_s = HTRANS_IDLE;
                        hwrite_s = 1'b0;
                    end else begin
                        idx_s    = idx_r + 2'd1;
                        haddr_s  = BASE_ADDR + W_ADDR'({idx_r + 2'd1, 2'b00});
                        hwrite_s = (idx_r != 2'd2);
                    end
                end else begin
                    state_s = ST_ADDR;
                end
            end
            ST_LAST: begin
                if (bus_err_s) begin
                    state_s = ST_ERR;
                end else if (m_HREADY) begin
                    state_s  = ST_IDLE;
                    done_s   = 1'b1;
                    err_s    = (m_HRESP != HRESP_OKAY);
                    result_s = (m_HRESP == HRESP_OKAY) ? m_HRDATA[31:0] : 32'h0;
                end else begin
                    state_s = ST_LAST;
                end
            end
            ST_ERR: begin
                htrans_s = HTRANS_IDLE;
                if (m_HREADY) begin
                    state_s  = ST_IDLE;
                    done_s   = 1'b1;
                    err_s    = 1'b1;
                    result_s = 32'h0;
                end else begin
                    state_s = ST_ERR;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                htrans_s = HTRANS_IDLE;
            end
        endcase
        ready_s = (state_s == ST_IDLE);
    end

    // State and registered-output update.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r  <= ST_IDLE;
            idx_r    <= 2'd0;
            htrans_r <= HTRANS_IDLE;
            haddr_r  <= {W_ADDR{1'b0}};
            hwrite_r <= 1'b0;
            hwdata_r <= {W_DATA{1'b0}};
            ready_r  <= 1'b1;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            result_r <= 32'h0;
            op_r     <= 4'h0;
            a_r      <= 32'h0;
            b_r      <= 32'h0;
        end else begin
            state_r  <= state_s;
            idx_r    <= idx_s;
            htrans_r <= htrans_s;
            haddr_r  <= haddr_s;
            hwrite_r <= hwrite_s;
            hwdata_r <= hwdata_s;
            ready_r  <= ready_s;
            done_r   <= done_s;
            err_r    <= err_s;
            result_r <= result_s;
            op_r     <= op_s;
            a_r      <= a_s;
            b_r      <= b_s;
        end
    end

    assign ready_o      = ready_r;
    assign done_o       = done_r;
    assign err_o        = err_r;
    assign result_o     = result_r;
    assign out_m_HTRANS = htrans_r;
    assign out_m_HBURST = 3'b000;
    assign out_m_HSIZE  = 3'b010;
    assign out_m_HPROT  = DEF_HPROT;
    assign out_m_HADDR  = haddr_r;
    assign out_m_HWRITE = hwrite_r;
    assign out_m_HWDATA = hwdata_r;

endmodule

// File: tb/tb_riscv_alu_ahb_master.sv
// Bench for riscv_alu_ahb_master: an AHB slave model with wait/error injection plus transfer and result scoreboards.
module tb_riscv_alu_ahb_master;

    logic        HCLK, HRESETn, start_i;
    logic [3:0]  op_i;
    logic [31:0] a_i, b_i;
    logic        ready_o, done_o, err_o;
    logic [31:0] result_o;
    logic [1:0]  out_m_HTRANS;
    logic [2:0]  out_m_HBURST, out_m_HSIZE;
    logic [3:0]  out_m_HPROT;
    logic [31:0] out_m_HADDR;
    logic        out_m_HWRITE;
    logic [31:0] out_m_HWDATA;
    logic        m_HREADY;
    logic [1:0]  m_HRESP;
    logic [31:0] m_HRDATA;

    riscv_alu_ahb_master dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .ready_o(ready_o), .done_o(done_o), .err_o(err_o), .result_o(result_o),
        .out_m_HTRANS(out_m_HTRANS), .out_m_HBURST(out_m_HBURST), .out_m_HSIZE(out_m_HSIZE),
        .out_m_HPROT(out_m_HPROT), .out_m_HADDR(out_m_HADDR), .out_m_HWRITE(out_m_HWRITE),
        .out_m_HWDATA(out_m_HWDATA), .m_HREADY(m_HREADY), .m_HRESP(m_HRESP), .m_HRDATA(m_HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct { logic [31:0] addr; logic wr; logic [31:0] data; } xfer_t;
    typedef struct { logic [31:0] res; logic err; } res_t;

    xfer_t       xq[$];
    res_t        rq[$];
    xfer_t       dp;
    logic        dp_valid;
    logic [31:0] sreg [4];
    logic        err_armed;
    int          err_stage;
    logic [31:0] err_addr, wait_addr;
    int          waits_left;
    int          cyc, n_checks, n_fail, done_cnt, last_done, acc_cyc;

    // ALU behaviour of the slave device.
    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    alu_model = a + b;
            4'd1:    alu_model = a - b;
            default: alu_model = a ^ b;
        endcase
    endfunction

    // One clock cycle: respond as the slave at the falling edge and score bus activity and completions.
    task automatic tick();
        xfer_t       nx;
        res_t        r;
        logic        rdy, took;
        logic [1:0]  resp;
        @(negedge HCLK);
        cyc++;
        rdy = 1'b1; resp = 2'b00; took = 1'b0; m_HRDATA = 32'h0;
        nx = '{32'h0, 1'b0, 32'h0};
        if (dp_valid) begin
            if (dp.wr) begin
                n_checks++;
                if (out_m_HWDATA !== dp.data) begin
                    n_fail++;
                    $display("FAIL hwdata addr=%h got %h want %h", dp.addr, out_m_HWDATA, dp.data);
                end
            end
            if (err_armed && err_stage == 0 && dp.addr == err_addr) begin
                rdy = 1'b0; resp = 2'b01; err_stage = 1;
            end else if (err_stage == 1) begin
                resp = 2'b01; err_stage = 2; err_armed = 1'b0;
                n_checks++;
                if (out_m_HTRANS !== 2'b00) begin
                    n_fail++;
                    $display("FAIL htrans_after_err got %b want 00", out_m_HTRANS);
                end
            end else if (waits_left > 0 && dp.addr == wait_addr) begin
                rdy = 1'b0; waits_left--;
            end else if (dp.wr) begin
                sreg[dp.addr[3:2]] = out_m_HWDATA;
            end else begin
                m_HRDATA = alu_model(sreg[0][3:0], sreg[1], sreg[2]);
            end
        end
        if (out_m_HTRANS === 2'b10) begin
            n_checks++;
            if (xq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_xfer addr=%h write=%b want no transfer", out_m_HADDR, out_m_HWRITE);
            end else begin
                if (out_m_HADDR !== xq[0].addr || out_m_HWRITE !== xq[0].wr || out_m_HSIZE !== 3'b010 ||
                    out_m_HBURST !== 3'b000 || out_m_HPROT !== 4'b0001) begin
                    n_fail++;
                    $display("FAIL addr_phase got addr=%h wr=%b size=%b burst=%b prot=%b want addr=%h wr=%b size=010 burst=000 prot=0001",
                             out_m_HADDR, out_m_HWRITE, out_m_HSIZE, out_m_HBURST, out_m_HPROT, xq[0].addr, xq[0].wr);
                end
                if (rdy) begin nx = xq.pop_front(); took = 1'b1; end
            end
        end else if (out_m_HTRANS !== 2'b00) begin
            n_checks++; n_fail++;
            $display("FAIL htrans_value got %b want 00 or 10", out_m_HTRANS);
        end
        if (rdy) begin dp_valid = took; dp = nx; end
        m_HREADY = rdy; m_HRESP = resp;
        if (done_o === 1'b1) begin
            done_cnt++; last_done = cyc; n_checks++;
            if (rq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done got done=1 want 0");
            end else begin
                r = rq.pop_front();
                if (result_o !== r.res || err_o !== r.err) begin
                    n_fail++;
                    $display("FAIL done_result got res=%h err=%b want res=%h err=%b", result_o, err_o, r.res, r.err);
                end
            end
        end else if (err_o !== 1'b0) begin
            n_checks++; n_fail++;
            $display("FAIL err_without_done got err=%b want 0", err_o);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic exp_err);
        n_checks++;
        if (ready_o !== 1'b1) begin n_fail++; $display("FAIL ready_before_issue got %b want 1", ready_o); end
        xq.push_back('{32'h0, 1'b1, {28'h0, op}});
        xq.push_back('{32'h4, 1'b1, a});
        xq.push_back('{32'h8, 1'b1, b});
        xq.push_back('{32'hC, 1'b0, 32'h0});
        if (exp_err) rq.push_back('{32'h0, 1'b1});
        else         rq.push_back('{alu_model(op, a, b), 1'b0});
        start_i = 1'b1; op_i = op; a_i = a; b_i = b; acc_cyc = cyc;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 60) begin tick(); n++; end
        n_checks++;
        if (done_cnt < target) begin n_fail++; $display("FAIL done_timeout got %0d dones want %0d", done_cnt, target); end
    endtask

    task automatic test_reset();
        HRESETn = 1'b0; start_i = 1'b0; op_i = 4'h0; a_i = 32'h0; b_i = 32'h0;
        m_HREADY = 1'b1; m_HRESP = 2'b00; m_HRDATA = 32'h0;
        tick(); tick();
        n_checks++;
        if ({out_m_HTRANS, out_m_HADDR, out_m_HWRITE, out_m_HWDATA, done_o, err_o, result_o} !== 103'h0 || ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state got htrans=%b addr=%h wr=%b wdata=%h done=%b err=%b res=%h ready=%b want all 0, ready 1",
                     out_m_HTRANS, out_m_HADDR, out_m_HWRITE, out_m_HWDATA, done_o, err_o, result_o, ready_o);
        end
        HRESETn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        issue(4'd0, 32'd5, 32'd7, 1'b0);
        wait_done(done_cnt + 1);
        n_checks++;
        if (last_done - acc_cyc != 6) begin n_fail++; $display("FAIL basic_latency got %0d want 6", last_done - acc_cyc); end
        tick();
        n_checks++;
        if (result_o !== 32'd12 || xq.size() != 0) begin
            n_fail++; $display("FAIL basic_result_held got %h pending=%0d want 0000000c pending=0", result_o, xq.size());
        end
    endtask

    task automatic test_wait_states();
        wait_addr = 32'h4; waits_left = 2;
        issue(4'd1, 32'd100, 32'd30, 1'b0);
        wait_done(done_cnt + 1);
        n_checks++;
        if (last_done - acc_cyc != 8 || result_o !== 32'd70) begin
            n_fail++; $display("FAIL wait_latency got %0d res=%h want 8 res=00000046", last_done - acc_cyc, result_o);
        end
    endtask

    task automatic test_back_to_back();
        int k2;
        issue(4'd0, 32'd1, 32'd2, 1'b0);
        wait_done(done_cnt + 1);
        issue(4'd0, 32'd3, 32'd4, 1'b0);
        k2 = acc_cyc;
        n_checks++;
        if (k2 != last_done) begin n_fail++; $display("FAIL b2b_accept got cycle %0d want %0d", k2, last_done); end
        wait_done(done_cnt + 1);
        n_checks++;
        if (last_done - k2 != 6 || result_o !== 32'd7 || xq.size() != 0) begin
            n_fail++; $display("FAIL b2b_second got lat=%0d res=%h pending=%0d want lat=6 res=7 pending=0",
                               last_done - k2, result_o, xq.size());
        end
    endtask

    task automatic test_error();
        err_armed = 1'b1; err_addr = 32'h8; err_stage = 0;
        issue(4'd2, 32'd9, 32'd3, 1'b1);
        wait_done(done_cnt + 1);
        n_checks++;
        if (last_done - acc_cyc != 6 || xq.size() != 1) begin
            n_fail++; $display("FAIL err_sequence got lat=%0d pending=%0d want lat=6 pending=1 (read)", last_done - acc_cyc, xq.size());
        end
        xq.delete();
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        int n, d0;
        issue(4'd0, 32'd11, 32'd22, 1'b0);
        n = 0;
        while (!(out_m_HTRANS === 2'b10 && out_m_HADDR === 32'hC) && n < 20) begin tick(); n++; end
        n_checks++;
        if (n >= 20) begin n_fail++; $display("FAIL read_addr_timeout got none want read address phase"); end
        HRESETn = 1'b0;
        #1;
        n_checks++;
        if (out_m_HTRANS !== 2'b00 || out_m_HADDR !== 32'h0 || out_m_HWDATA !== 32'h0 || ready_o !== 1'b1 || done_o !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got htrans=%b addr=%h wdata=%h ready=%b done=%b want 00/0/0/1/0",
                               out_m_HTRANS, out_m_HADDR, out_m_HWDATA, ready_o, done_o);
        end
        xq.delete(); rq.delete(); dp_valid = 1'b0;
        d0 = done_cnt;
        tick(); tick();
        HRESETn = 1'b1;
        tick();
        n_checks++;
        if (out_m_HTRANS !== 2'b00 || done_cnt != d0) begin
            n_fail++; $display("FAIL post_reset got htrans=%b dones=%0d want 00 dones=%0d", out_m_HTRANS, done_cnt, d0);
        end
        issue(4'd0, 32'd40, 32'd2, 1'b0);
        wait_done(done_cnt + 1);
        n_checks++;
        if (last_done - acc_cyc != 6 || result_o !== 32'd42) begin
            n_fail++; $display("FAIL post_reset_req got lat=%0d res=%h want 6 res=0000002a", last_done - acc_cyc, result_o);
        end
    endtask

    task automatic test_capture();
        issue(4'd1, 32'd50, 32'd8, 1'b0);
        a_i = 32'hDEAD_BEEF; b_i = 32'h1234_5678; op_i = 4'h2;
        wait_done(done_cnt + 1);
        n_checks++;
        if (result_o !== 32'd42) begin n_fail++; $display("FAIL capture_result got %h want 0000002a", result_o); end
    endtask

    initial begin
        cyc = 0; n_checks = 0; n_fail = 0; done_cnt = 0; last_done = 0; acc_cyc = 0;
        dp_valid = 1'b0; dp = '{32'h0, 1'b0, 32'h0};
        err_armed = 1'b0; err_stage = 0; err_addr = 32'h0; wait_addr = 32'h0; waits_left = 0;
        for (int i = 0; i < 4; i++) sreg[i] = 32'h0;
        test_reset();
        test_basic();
        test_wait_states();
        test_back_to_back();
        test_error();
        test_reset_mid();
        test_capture();
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no finish want finish before 100000");
        $fatal(1);
    end

endmodule

// File: doc/riscv_alu_ahb_master.md
RISCV_ALU_AHB_MASTER -- requirements
Module: riscv_alu_ahb_master

Interface
REQ-001 Parameter W_ADDR, default 32: AHB address width.
REQ-002 Parameter W_DATA, default 32: AHB data width.
REQ-003 Parameter BASE_ADDR, default 32'h0: base address of the ALU slave; register offsets are 0x00 op, 0x04 A, 0x08 B, 0x0C result.
REQ-004 Parameter DEF_HPROT, default {PROT_NOTCACHE, PROT_UNBUF, PROT_USER, PROT_DATA}: HPROT value for all transfers.
REQ-005 Clock and reset: one clock, HCLK; reset HRESETn, asynchronous, active-low.
REQ-006 Ports, as name / direction / width / meaning:
- HCLK  in  1  clock
- HRESETn  in  1  async active-low reset
- start_i  in  1  request valid
- op_i  in  4  ALU opcode
- a_i  in  32  operand A
- b_i  in  32  operand B
- ready_o  out  1  block idle; request accepted when start_i && ready_o
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle error pulse, coincident with done_o
- result_o  out  32  ALU result, held until next done_o
- out_m_HTRANS  out  2  transfer type
- out_m_HBURST  out  3  always SINGLE
- out_m_HSIZE  out  3  always word (3'b010)
- out_m_HPROT  out  4  always DEF_HPROT
- out_m_HADDR  out  W_ADDR  address
- out_m_HWRITE  out  1  write/read
- out_m_HWDATA  out  W_DATA  write data
- m_HREADY  in  1  transfer done / bus ready
- m_HRESP  in  2  slave response
- m_HRDATA  in  W_DATA  read data

Function
REQ-007 On acceptance, op_i, a_i and b_i SHALL be captured; later input changes SHALL have no effect.
REQ-008 Each accepted request SHALL issue exactly four transfers in order:
- write BASE+0x00, data {28'b0, op}
- write BASE+0x04, data A
- write BASE+0x08, data B
- read BASE+0x0C
REQ-009 Each transfer SHALL use HTRANS=NONSEQ; at all other times HTRANS SHALL be IDLE, with HADDR and HWRITE don't-care.
REQ-010 Transfers SHALL be pipelined: the address phase of transfer n+1 SHALL overlap the data phase of transfer n.
REQ-011 HWDATA SHALL carry the write data of the transfer currently in its data phase.
REQ-012 A phase SHALL advance only on a rising edge with m_HREADY=1. While m_HREADY=0, HTRANS, HADDR, HWRITE and HWDATA SHALL be held stable.
REQ-013 m_HRDATA SHALL be sampled into result_o at the edge ending the read data phase with m_HREADY=1 and m_HRESP=OKAY.
REQ-014 The FSM SHALL have states IDLE, ADDR, LAST, ERR:
- IDLE->ADDR on acceptance.
- ADDR stays in ADDR while address phases of transfers 0-3 are issued.
- ADDR->LAST when the read address phase completes.
- LAST->IDLE when the read data phase completes; done_o pulses in the following cycle.
REQ-015 With zero wait states, for a request accepted at edge k: address phases SHALL occupy cycles k+1..k+4, data phases k+2..k+5, and done_o SHALL be high in cycle k+6.
REQ-016 ready_o SHALL be high only in IDLE, including the done_o cycle. Back-to-back requests SHALL be supported.
REQ-017 Error response: m_HRESP=ERROR with m_HREADY=0 in any data phase:
- Next cycle: HTRANS SHALL be IDLE, cancelling any pending address phase; FSM enters ERR.
- On the second error cycle (m_HREADY=1): FSM returns to IDLE and no further transfers are issued.
- In the following cycle: done_o=1, err_o=1, result_o=0.
REQ-018 RETRY and SPLIT responses SHALL be treated as ERROR.

Reset
REQ-019 While HRESETn=0, asynchronously:
- FSM=IDLE, ready_o=1, done_o=0, err_o=0, result_o=0
- HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0
- captured operands=0
REQ-020 Reset asserted mid-sequence SHALL abandon the sequence with no done_o. After release, the first cycle SHALL drive HTRANS=IDLE.

Verification
REQ-021 Zero-wait request, op=0 (ADD), A=5, B=7, slave returns 12 -> writes 0x0/0x4/0x8 with data 0/5/7, read 0xC, done_o at k+6, result_o=12, err_o=0.
REQ-022 Slave inserts 2 wait states on the A write -> address and data held stable for 2 extra cycles, done_o at k+8, correct result.
REQ-023 Two requests back-to-back, A=1/B=2 then A=3/B=4 -> second accepted in the first's done_o cycle, eight correctly ordered transfers, two done_o pulses.
REQ-024 ERROR on the B write -> read never issued, HTRANS=IDLE from the second error cycle, done_o=err_o=1, result_o=0.
REQ-025 HRESETn pulsed low during the read address phase -> outputs at reset values immediately, no done_o, new request after release completes normally.
REQ-026 a_i/b_i changed the cycle after acceptance -> transferred data equal the captured values.
